fpu_ss_wb_ctrl: RTL and testbench
=================================

// Module: fpu_ss_wb_ctrl
// PURPOSE
//  Owns the FPU subsystem register file's single write port. Arbitrates two writeback
//  sources (FPU result, LSU load data) onto it round-robin. Keeps a busy-bit scoreboard
//  over all NumRegs FP registers, so the decoder issues only when operands/dest are clean.
//  Sits between the issue stage, the FPU/LSU result paths and the register file.
// PARAMETERS
//  NumRegs   32  FP registers tracked; all are real registers, f0 included
//  AddrWidth 5   register address width, $clog2(NumRegs)
//  DataWidth 32  writeback data width
//  NumRs     3   source-operand hazard-check ports
// PORTS
//  clk_i        in   1                  clock
//  rst_ni       in   1                  asynchronous active-low reset
//  issue_valid_i in  1                  decoder presents an instruction
//  issue_we_i   in   1                  instruction writes an FP rd
//  issue_rd_i   in   AddrWidth          destination register
//  issue_rs_i   in   NumRs x AddrWidth  source registers
//  issue_rs_en_i in  NumRs              source register n is actually read
//  issue_ready_o out 1                  no hazard; handshake completes when valid&ready
//  fpu_valid_i  in   1                  FPU result valid
//  fpu_rd_i     in   AddrWidth          FPU result destination
//  fpu_data_i   in   DataWidth          FPU result data
//  fpu_ready_o  out  1                  FPU result accepted this cycle
//  lsu_valid_i  in   1                  load data valid
//  lsu_rd_i     in   AddrWidth          load destination
//  lsu_data_i   in   DataWidth          load data
//  lsu_ready_o  out  1                  load data accepted this cycle
//  rf_we_o      out  1                  register-file write enable
//  rf_waddr_o   out  AddrWidth          register-file write address
//  rf_wdata_o   out  DataWidth          register-file write data
//  busy_o       out  NumRegs            scoreboard state, debug/observe
// BEHAVIOUR
//  - Reset: busy all 0, rr pointer = FPU-first; rf_we_o, fpu_ready_o, lsu_ready_o = 0.
//  - Write path is combinational, 0-cycle: rf_we_o = fpu_ready_o | lsu_ready_o.
//    waddr/wdata are muxed from the granted source and are 0 when neither is granted.
//  - Arbitration:
//    * Only one valid source: it is granted.
//    * Both valid: grant the source favoured by rr_q.
//    * rr_q flips to favour the other source only when both were valid and one granted.
//    * The losing source holds valid/rd/data stable until granted; no drop, no reorder per source.
//  - Scoreboard: busy[r] sets on issue handshake with issue_we_i, r = issue_rd_i.
//    busy[r] clears on rf_we_o with r = rf_waddr_o.
//    * Same r set and cleared in one cycle: set wins, result is busy.
//  - Hazard: issue_ready_o = 0 if busy[issue_rd_i] & issue_we_i (WAW), or any enabled
//    rs has busy set (RAW).
//    * Check uses registered busy_q only; a writeback clearing a bit this cycle does not
//      unblock issue until the next cycle.
//    * issue_ready_o must not depend on issue_valid_i.
//  - Writeback to a register whose busy bit is 0 is legal: the write happens, busy stays 0.
//  - Reset asserted mid-operation: all busy bits and rr_q clear immediately; outstanding
//    results are discarded by the environment.
// STRUCTURE
//  - fpu_ss_pkg: wb_src_e {WB_FPU, WB_LSU}; localparam FpNumRegs = 32.
//  - Sub-module fpu_ss_rr_arb2: 2-input round-robin arbiter, holds rr_q, returns one-hot grant.
//  - Scoreboard register, hazard compare and write mux stay in this module.
// TESTING
//  - Reset, then idle: rf_we_o=0, busy_o=0, issue_ready_o=1 for rd=5, rs={1,2,3}.
//  - Issue rd=5, then issue rs0=5 -> ready=0. FPU writeback rd=5, data=32'h3F80_0000
//    -> rf_we_o=1, waddr=5; next cycle ready=1, busy[5]=0.
//  - FPU rd=3 and LSU rd=4 valid together for 3 cycles, rr reset:
//    grants FPU, LSU, then FPU (the still-valid FPU source).
//  - Issue rd=7 while LSU writes rd=7 the same cycle (busy[7] was 0) -> busy[7]=1 afterwards.
//  - busy[9]=1, issue rd=9 with rs disabled -> ready=0 (WAW); clears one cycle after rd=9 writeback.
//  - Set busy[0] and busy[31], assert rst_ni=0 mid-cycle -> busy_o=0 and all ready/we low
//    asynchronously.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ss_pkg
//  Purpose  : Shared types and constants for the FPU subsystem writeback path.
//  Revision : 1.0 - initial release
// ============================================================================
package fpu_ss_pkg;

  localparam int FpNumRegs = 32;

  // Writeback source identity; also used as the round-robin favour pointer.
  typedef enum logic [0:0] {
    WB_FPU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/fpu_ss_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ss_wb_ctrl_if
//  Purpose  : Issue, FPU/LSU writeback and register-file write bundle.
//             Signal suffixes are from the controller's point of view.
//  Revision : 1.0 - initial release
// ============================================================================
interface fpu_ss_wb_ctrl_if #(
  parameter int AddrWidth = 5,
  parameter int DataWidth = 32,
  parameter int NumRs     = 3
);
  // Issue stage
  logic                            issue_valid_i;
  logic                            issue_we_i;
  logic [AddrWidth-1:0]            issue_rd_i;
  logic [NumRs-1:0][AddrWidth-1:0] issue_rs_i;
  logic [NumRs-1:0]                issue_rs_en_i;
  logic                            issue_ready_o;
  // FPU result path
  logic                            fpu_valid_i;
  logic [AddrWidth-1:0]            fpu_rd_i;
  logic [DataWidth-1:0]            fpu_data_i;
  logic                            fpu_ready_o;
  // LSU load path
  logic                            lsu_valid_i;
  logic [AddrWidth-1:0]            lsu_rd_i;
  logic [DataWidth-1:0]            lsu_data_i;
  logic                            lsu_ready_o;
  // Register-file write port
  logic                            rf_we_o;
  logic [AddrWidth-1:0]            rf_waddr_o;
  logic [DataWidth-1:0]            rf_wdata_o;

  // Environment side: drives requests, observes grants and the write port.
  modport master (
    output issue_valid_i, issue_we_i, issue_rd_i, issue_rs_i, issue_rs_en_i,
    output fpu_valid_i, fpu_rd_i, fpu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_ready_o, fpu_ready_o, lsu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );

  // Controller side.
  modport slave (
    input  issue_valid_i, issue_we_i, issue_rd_i, issue_rs_i, issue_rs_en_i,
    input  fpu_valid_i, fpu_rd_i, fpu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_ready_o, fpu_ready_o, lsu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/fpu_ss_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ss_rr_arb2
//  Purpose  : Two-input round-robin arbiter with one-hot grant.
//             Bit 0 = FPU, bit 1 = LSU. The favour pointer only moves when
//             both inputs contend, so a lone requester never steals a turn.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_ss_rr_arb2
  import fpu_ss_pkg::*;
(
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  input  wire logic [1:0] i_req,
  output logic      [1:0] o_gnt
);

  wb_src_e    r_rr;
  wb_src_e    w_rr_d;
  logic [1:0] w_gnt;

  // Grant selection and next favour pointer.
  always_comb begin
    w_gnt  = i_req;
    w_rr_d = r_rr;
    if (i_req == 2'b11) begin
      if (r_rr == WB_FPU) begin
        w_gnt  = 2'b01;
        w_rr_d = WB_LSU;
      end else begin
        w_gnt  = 2'b10;
        w_rr_d = WB_FPU;
      end
    end
  end

  // Favour pointer register; FPU first out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rr <= WB_FPU;
    else         r_rr <= w_rr_d;
  end

  // No grant while reset is held, even if requesters are still asserted.
  assign o_gnt = w_gnt & {2{rst_ni}};

endmodule
`default_nettype wire

// File: rtl/fpu_ss_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ss_wb_ctrl
//  Purpose  : Owns the FP register-file write port. Round-robin arbitrates
//             FPU and LSU writebacks and keeps a busy-bit scoreboard that
//             holds off issue on RAW/WAW hazards.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_ss_wb_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int NumRegs   = FpNumRegs,
  parameter int AddrWidth = $clog2(NumRegs),
  parameter int DataWidth = 32,
  parameter int NumRs     = 3
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  fpu_ss_wb_ctrl_if.slave   bus,
  output logic [NumRegs-1:0] busy_o
);

  logic [NumRegs-1:0]   r_busy;
  logic [NumRegs-1:0]   w_busy_d;
  logic [1:0]           w_gnt;
  logic                 w_we;
  logic [AddrWidth-1:0] w_waddr;
  logic [DataWidth-1:0] w_wdata;
  logic [NumRs-1:0]     w_raw;
  logic                 w_waw;
  logic                 w_ready;
  logic                 w_issue_fire;

  fpu_ss_rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_req  ({bus.lsu_valid_i, bus.fpu_valid_i}),
    .o_gnt  (w_gnt)
  );

  assign w_we = |w_gnt;

  // Write-port mux; address and data read as zero when nothing is granted.
  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    if (w_gnt[0]) begin
      w_waddr = bus.fpu_rd_i;
      w_wdata = bus.fpu_data_i;
    end else if (w_gnt[1]) begin
      w_waddr = bus.lsu_rd_i;
      w_wdata = bus.lsu_data_i;
    end
  end

  // Hazard checks look only at the registered scoreboard, so a writeback
  // in flight this cycle unblocks issue one cycle later.
  for (genvar g = 0; g < NumRs; g++) begin : g_rs
    assign w_raw[g] = bus.issue_rs_en_i[g] & r_busy[bus.issue_rs_i[g]];
  end

  assign w_waw        = bus.issue_we_i & r_busy[bus.issue_rd_i];
  assign w_ready      = rst_ni & ~w_waw & ~(|w_raw);
  assign w_issue_fire = bus.issue_valid_i & w_ready;

  // Scoreboard update: clear on writeback first, then set on issue so that
  // a same-cycle set and clear of one register leaves it busy.
  always_comb begin
    w_busy_d = r_busy;
    if (w_we) w_busy_d[w_waddr] = 1'b0;
    if (w_issue_fire && bus.issue_we_i) w_busy_d[bus.issue_rd_i] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_d;
  end

  assign bus.issue_ready_o = w_ready;
  assign bus.fpu_ready_o   = w_gnt[0];
  assign bus.lsu_ready_o   = w_gnt[1];
  assign bus.rf_we_o       = w_we;
  assign bus.rf_waddr_o    = w_waddr;
  assign bus.rf_wdata_o    = w_wdata;
  assign busy_o            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_ss_wb_ctrl
//  Purpose  : Self-checking bench for fpu_ss_wb_ctrl: directed scenarios
//             followed by randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_ss_wb_ctrl;

  typedef struct {
    int          src;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_ni;
  logic [31:0] busy;

  fpu_ss_wb_ctrl_if #(.AddrWidth(5), .DataWidth(32), .NumRs(3)) u_if ();

  fpu_ss_wb_ctrl #(.NumRegs(32), .AddrWidth(5), .DataWidth(32), .NumRs(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (u_if.slave),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: which registers are pending, who is favoured.
  logic [31:0] m_busy;
  int          m_fav;
  int          last_g;
  exp_t        exp_q[$];

  // Values sampled from the DUT on the falling edge of the last step.
  logic        s_ready, s_we, s_fpu_rdy, s_lsu_rdy;
  logic [4:0]  s_waddr;
  logic [31:0] s_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    u_if.issue_valid_i = 0; u_if.issue_we_i = 0; u_if.issue_rd_i = 0;
    u_if.issue_rs_i = '0; u_if.issue_rs_en_i = 0;
    u_if.fpu_valid_i = 0; u_if.fpu_rd_i = 0; u_if.fpu_data_i = 0;
    u_if.lsu_valid_i = 0; u_if.lsu_rd_i = 0; u_if.lsu_data_i = 0;
  endtask

  task automatic set_issue(input logic v, input logic we, input logic [4:0] rd,
                           input logic [2:0] en, input logic [4:0] r0,
                           input logic [4:0] r1, input logic [4:0] r2);
    u_if.issue_valid_i = v; u_if.issue_we_i = we; u_if.issue_rd_i = rd;
    u_if.issue_rs_en_i = en;
    u_if.issue_rs_i[0] = r0; u_if.issue_rs_i[1] = r1; u_if.issue_rs_i[2] = r2;
  endtask

  // One clock cycle: predict from the model, check at the falling edge,
  // advance the model at the rising edge. Called 1 time unit after posedge.
  task automatic step();
    logic m_rdy;
    int   g;
    logic fv, lv;
    logic [31:0] nb;
    m_rdy = 1'b1;
    if (u_if.issue_we_i && m_busy[u_if.issue_rd_i]) m_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      if (u_if.issue_rs_en_i[i] && m_busy[u_if.issue_rs_i[i]]) m_rdy = 1'b0;
    fv = u_if.fpu_valid_i;
    lv = u_if.lsu_valid_i;
    g  = -1;
    if (fv && lv) g = m_fav;
    else if (fv)  g = 0;
    else if (lv)  g = 1;
    if (g == 0) exp_q.push_back('{0, u_if.fpu_rd_i, u_if.fpu_data_i});
    if (g == 1) exp_q.push_back('{1, u_if.lsu_rd_i, u_if.lsu_data_i});
    @(negedge clk);
    s_ready = u_if.issue_ready_o; s_we = u_if.rf_we_o; s_waddr = u_if.rf_waddr_o;
    s_fpu_rdy = u_if.fpu_ready_o; s_lsu_rdy = u_if.lsu_ready_o; s_busy = busy;
    chk("issue_ready", 64'(s_ready), 64'(m_rdy));
    chk("busy", 64'(s_busy), 64'(m_busy));
    if (g < 0) chk("rf_we_idle", 64'(s_we), 64'd0);
    @(posedge clk);
    nb = m_busy;
    if (g == 0) nb[u_if.fpu_rd_i] = 1'b0;
    if (g == 1) nb[u_if.lsu_rd_i] = 1'b0;
    if (u_if.issue_valid_i && m_rdy && u_if.issue_we_i) nb[u_if.issue_rd_i] = 1'b1;
    m_busy = nb;
    if (fv && lv) m_fav = 1 - g;
    last_g = g;
    #1;
  endtask

  // Prefer registers that are pending so writebacks usually retire something.
  function automatic logic [4:0] pick_rd();
    int n;
    int k;
    n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    if (n == 0 || $urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < 32; i++)
      if (m_busy[i]) begin
        if (k == 0) return 5'(i);
        k--;
      end
    return 5'd0;
  endfunction

  task automatic stimulus();
    logic fpu_pend, lsu_pend;
    // Reset and idle
    rst_ni = 1'b0; idle_inputs();
    m_busy = '0; m_fav = 0; last_g = -1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_we", 64'(u_if.rf_we_o), 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    set_issue(0, 1, 5, 3'b111, 1, 2, 3);
    step();
    chk("idle_ready", 64'(s_ready), 64'd1);
    chk("idle_we", 64'(s_we), 64'd0);

    // Issue rd=5, then RAW on rs0=5, then FPU writeback of rd=5
    set_issue(1, 1, 5, 3'b000, 0, 0, 0);
    step();
    set_issue(1, 0, 0, 3'b001, 5, 0, 0);
    step();
    chk("raw_ready", 64'(s_ready), 64'd0);
    u_if.fpu_valid_i = 1; u_if.fpu_rd_i = 5; u_if.fpu_data_i = 32'h3F80_0000;
    step();
    chk("wb5_we", 64'(s_we), 64'd1);
    chk("wb5_addr", 64'(s_waddr), 64'd5);
    chk("wb5_ready_same_cycle", 64'(s_ready), 64'd0);
    u_if.fpu_valid_i = 0;
    step();
    chk("wb5_ready_next", 64'(s_ready), 64'd1);
    chk("wb5_busy_clear", 64'(s_busy[5]), 64'd0);

    // Contention: FPU, LSU, FPU
    set_issue(0, 0, 0, 3'b000, 0, 0, 0);
    u_if.fpu_valid_i = 1; u_if.fpu_rd_i = 3; u_if.fpu_data_i = 32'hAAAA_0001;
    u_if.lsu_valid_i = 1; u_if.lsu_rd_i = 4; u_if.lsu_data_i = 32'hBBBB_0002;
    step();
    chk("rr1_fpu", 64'({s_lsu_rdy, s_fpu_rdy}), 64'b01);
    u_if.fpu_data_i = 32'hAAAA_0003;
    step();
    chk("rr2_lsu", 64'({s_lsu_rdy, s_fpu_rdy}), 64'b10);
    u_if.lsu_data_i = 32'hBBBB_0004;
    step();
    chk("rr3_fpu", 64'({s_lsu_rdy, s_fpu_rdy}), 64'b01);
    u_if.fpu_valid_i = 0; u_if.lsu_valid_i = 0;
    step();

    // Same-cycle set and clear of rd=7: set wins
    set_issue(1, 1, 7, 3'b000, 0, 0, 0);
    u_if.lsu_valid_i = 1; u_if.lsu_rd_i = 7; u_if.lsu_data_i = 32'h0000_0777;
    step();
    idle_inputs();
    step();
    chk("set_wins_busy7", 64'(s_busy[7]), 64'd1);

    // WAW on rd=9
    set_issue(1, 1, 9, 3'b000, 0, 0, 0);
    step();
    step();
    chk("waw_ready", 64'(s_ready), 64'd0);
    u_if.fpu_valid_i = 1; u_if.fpu_rd_i = 9; u_if.fpu_data_i = 32'h0000_0999;
    step();
    chk("waw_ready_wb_cycle", 64'(s_ready), 64'd0);
    u_if.fpu_valid_i = 0; u_if.issue_valid_i = 0;
    step();
    chk("waw_ready_after", 64'(s_ready), 64'd1);

    // Randomized traffic
    idle_inputs();
    fpu_pend = 0; lsu_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!fpu_pend && $urandom_range(0, 1) == 1) begin
        fpu_pend = 1; u_if.fpu_rd_i = pick_rd(); u_if.fpu_data_i = $urandom;
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; u_if.lsu_rd_i = pick_rd(); u_if.lsu_data_i = $urandom;
      end
      u_if.fpu_valid_i = fpu_pend;
      u_if.lsu_valid_i = lsu_pend;
      set_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
      if (last_g == 0) fpu_pend = 0;
      if (last_g == 1) lsu_pend = 0;
    end

    // Asynchronous reset with busy[0] and busy[31] set
    idle_inputs();
    step();
    set_issue(1, 1, 0, 3'b000, 0, 0, 0);
    step();
    set_issue(1, 1, 31, 3'b000, 0, 0, 0);
    step();
    chk("pre_reset_busy", 64'(busy & 32'h8000_0001), 64'h8000_0001);
    set_issue(0, 0, 1, 3'b000, 0, 0, 0);
    u_if.fpu_valid_i = 1; u_if.fpu_rd_i = 2; u_if.lsu_valid_i = 1; u_if.lsu_rd_i = 6;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_we", 64'(u_if.rf_we_o), 64'd0);
    chk("async_rdy", 64'({u_if.issue_ready_o, u_if.lsu_ready_o, u_if.fpu_ready_o}), 64'd0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1 rst_ni = 1'b1;
    m_busy = '0; m_fav = 0;
    exp_q.delete();
    step();
    chk("post_reset_ready", 64'(s_ready), 64'd1);
    chk("wb_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Writeback monitor: every register-file write must match the oldest
  // predicted writeback in order.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && u_if.rf_we_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: write to %0d data %0h with none predicted",
                   u_if.rf_waddr_o, u_if.rf_wdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("wb_src", 64'({u_if.lsu_ready_o, u_if.fpu_ready_o}), (e.src == 0) ? 64'b01 : 64'b10);
          chk("wb_addr", 64'(u_if.rf_waddr_o), 64'(e.addr));
          chk("wb_data", 64'(u_if.rf_wdata_o), 64'(e.data));
        end
      end
    end
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
